// File: rtl/station_cmd_ctrl_if.sv
// Command/reader/motion signal bundle for station_cmd_ctrl.
// slave = the sequencer itself, master = UART/reader/motor side.
interface station_cmd_ctrl_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  ID;
    logic        ID_vld;
    logic        clr_ID_vld;
    logic        OK2Move;
    logic        go;
    logic        in_transit;
    logic        arrived;
    logic        buzz;
    logic        buzz_n;

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
        output clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived, buzz, buzz_n
    );

    modport master (
        output cmd, cmd_rdy, ID, ID_vld, OK2Move,
        input  clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived, buzz, buzz_n
    );
endinterface

// File: rtl/station_cmd_ctrl.sv
// Go/stop command sequencer with barcode-station arrival detection and obstacle buzzer.
// Optional buzzer logic is built only when STN_BUZZ_EN is defined.
module station_cmd_ctrl #(
    parameter int BUZZ_DIV = 12500
) (
    input  logic                clk,
    input  logic                rst_n,
    station_cmd_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, MOVE} state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;

    state_t     state_q, state_d;
    logic       in_transit_q, in_transit_d;
    logic [5:0] dest_q, dest_d;
    logic       arrived_q, arrived_d;
    logic       clr_cmd, clr_id;
    logic [1:0] opcode;
    logic       id_match;

    // Only opcode and destination fields of the command word carry meaning.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^bus.cmd[13:6];

    assign opcode   = bus.cmd[15:14];
    assign id_match = (bus.ID[7:6] == 2'b00) && (bus.ID[5:0] == dest_q);

    always_comb begin
        state_d      = state_q;
        in_transit_d = in_transit_q;
        dest_d       = dest_q;
        arrived_d    = 1'b0;
        clr_cmd      = 1'b0;
        clr_id       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    clr_cmd = 1'b1;
                    if (opcode == OP_GO) begin
                        dest_d       = bus.cmd[5:0];
                        in_transit_d = 1'b1;
                        state_d      = MOVE;
                    end
                end else if (bus.ID_vld) begin
                    clr_id = 1'b1;
                end
            end
            MOVE: begin
                // A pending ID report waits behind a command and is judged
                // against whatever dest/state the command leaves behind.
                if (bus.cmd_rdy) begin
                    clr_cmd = 1'b1;
                    if (opcode == OP_GO) begin
                        dest_d = bus.cmd[5:0];
                    end else if (opcode == OP_STOP) begin
                        in_transit_d = 1'b0;
                        state_d      = IDLE;
                    end
                end else if (bus.ID_vld) begin
                    clr_id = 1'b1;
                    if (id_match) begin
                        in_transit_d = 1'b0;
                        arrived_d    = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_transit_q <= 1'b0;
            dest_q       <= 6'h00;
            arrived_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_transit_q <= in_transit_d;
            dest_q       <= dest_d;
            arrived_q    <= arrived_d;
        end
    end

    assign bus.clr_cmd_rdy = clr_cmd;
    assign bus.clr_ID_vld  = clr_id;
    assign bus.in_transit  = in_transit_q;
    assign bus.arrived     = arrived_q;
    assign bus.go          = in_transit_q & bus.OK2Move;

`ifdef STN_BUZZ_EN
    localparam int CNT_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUZZ_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buzz_q, buzz_d;
    logic             stalled;

    assign stalled = in_transit_q & ~bus.OK2Move;

    // Tone runs only while a move is blocked; clearing restarts it from silence.
    always_comb begin
        cnt_d  = '0;
        buzz_d = 1'b0;
        if (stalled) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                buzz_d = ~buzz_q;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                buzz_d = buzz_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            buzz_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buzz_q <= buzz_d;
        end
    end

    assign bus.buzz   = buzz_q;
    assign bus.buzz_n = ~buzz_q;
`else
    localparam int unused_buzz_div = BUZZ_DIV;

    assign bus.buzz   = 1'b0;
    assign bus.buzz_n = 1'b1;
`endif

endmodule

// File: doc/station_cmd_ctrl.md
Name: station_cmd_ctrl

Overview:
Command sequencer for the line-follower that owns the barcode station reader. It accepts go/stop commands from the UART command path, latches a destination station ID, and enables motion. It consumes each reader ID_vld/ID report and stops the vehicle when the scanned station matches the destination. It also drives the obstacle buzzer while a move is stalled by OK2Move.

Parameters:
BUZZ_DIV, 12500, clk cycles between buzz toggles (2 kHz tone at 50 MHz); counter width = $clog2(BUZZ_DIV).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd  input  16  command word; [15:14] opcode, [5:0] destination station
cmd_rdy  input  1  command word valid (held until cleared)
clr_cmd_rdy  output  1  one-cycle consume strobe for cmd_rdy
ID  input  8  station ID from barcode reader
ID_vld  input  1  ID valid (held until cleared)
clr_ID_vld  output  1  one-cycle consume strobe for ID_vld
OK2Move  input  1  1 = path clear (no obstacle)
go  output  1  motion enable to motor control
in_transit  output  1  move in progress
arrived  output  1  one-cycle pulse on destination match
buzz  output  1  piezo drive
buzz_n  output  1  complement of buzz

Behaviour:
- Reset (async, rst_n low): state IDLE, in_transit=0, dest=6'h00, arrived=0, buzz=0, buzz_n=1, buzz counter=0.
- Opcodes: 2'b01 GO, 2'b00 STOP, 2'b1x reserved (consumed, no effect).
- Station ID valid only when ID[7:6]==2'b00; match = valid && ID[5:0]==dest.
- clr_cmd_rdy and clr_ID_vld are combinational Mealy outputs, asserted in the same cycle the flag is consumed. At most one consume strobe per cycle.
- IDLE:
  - cmd_rdy: assert clr_cmd_rdy.
    - GO: dest<=cmd[5:0], in_transit<=1, next state MOVE.
    - STOP/reserved: stay in IDLE.
  - else ID_vld: assert clr_ID_vld (discard report), stay in IDLE.
- MOVE:
  - cmd_rdy: assert clr_cmd_rdy.
    - GO: dest<=cmd[5:0] (retarget), stay in MOVE.
    - STOP: in_transit<=0, next state IDLE.
    - reserved: stay in MOVE.
  - else ID_vld: assert clr_ID_vld.
    - match: in_transit<=0, arrived<=1 for exactly one cycle, next state IDLE.
    - no match or invalid ID: stay in MOVE.
- Simultaneous cmd_rdy and ID_vld: cmd_rdy wins. ID_vld is left pending and is handled in the next eligible cycle against the possibly new dest/state.
- go = in_transit & OK2Move, combinational, no latency.
- in_transit rises and falls one clock after the consuming cycle.
- Buzzer:
  - Active while in_transit & ~OK2Move: counter increments each cycle; at BUZZ_DIV-1 it wraps to 0 and buzz toggles.
  - Inactive: counter=0, buzz=0.
  - buzz_n = ~buzz at all times.
- Reset asserted mid-move: immediate return to reset values; pending flags are not cleared by this block.

Optional Feature:
STN_BUZZ_EN
- Defined: buzzer logic as described above.
- Undefined: no buzz counter is instantiated; buzz tied 0, buzz_n tied 1; all other behaviour unchanged.

Test Plan:
- Reset, then cmd=16'h4005 with cmd_rdy=1 -> clr_cmd_rdy high that cycle; next cycle in_transit=1, dest=5, go=1 (OK2Move=1).
- In MOVE with dest=5: ID_vld and ID=8'h03 -> clr_ID_vld pulse, stays MOVE. Then ID=8'h45 (invalid, bits[7:6]=01) -> stays MOVE. Then ID=8'h05 -> arrived pulses one cycle, in_transit=0, go=0.
- In MOVE: cmd=16'h0000 STOP -> in_transit=0 next cycle, no arrived pulse. In IDLE: ID_vld -> clr_ID_vld pulse, state unchanged.
- Same cycle cmd_rdy (GO dest=9, cmd=16'h4009) and ID_vld (ID=8'h05, dest=5) -> only clr_cmd_rdy; next cycle ID consumed against dest=9, no arrival.
- BUZZ_DIV=4, in_transit=1, OK2Move=0 -> buzz toggles every 4 cycles, buzz_n complementary, go=0. OK2Move back to 1 -> buzz=0, counter=0 the next cycle.
- Build without STN_BUZZ_EN, repeat previous stimulus -> buzz constant 0, buzz_n constant 1.
